// File: rtl/ui_message_ctrl.sv
// ui_message_ctrl: overlay sequencer with frame-timed result hold and serial slot-to-BCD conversion.
// Optional macro UI_MESSAGE_FRAME_SYNC_EN makes the overlay outputs update only on frame ticks.
module ui_message_ctrl #(
    parameter int HOLD_FRAMES = 120,
    parameter int SLOT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  camera_detected,
    input  logic                  export_start,
    input  logic                  export_done,
    input  logic                  export_fail,
    input  logic [SLOT_WIDTH-1:0] export_slot,
    output logic                  ui_enable,
    output logic [2:0]            string_index,
    output logic [7:0]            save_index_bcd,
    output logic                  busy
);
    localparam int HOLD_EFF = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;
    localparam int HW = $clog2(HOLD_EFF + 1);
    localparam logic [2:0] IDLE = 3'd0, NODET = 3'd1, EXPORT = 3'd2, CONVERT = 3'd3, SAVED = 3'd4, FAILED = 3'd5;
    logic [2:0]    state, state_nx, nx_idx;
    logic [HW-1:0] hold;
    logic [6:0]    rem;
    logic [3:0]    tens;
    logic [7:0]    bcd;
    logic          vsync_d, tick, conv_done, save_done, hold_exit, disp_load;
    assign tick      = vsync & ~vsync_d;
    assign conv_done = (state == CONVERT) && (rem < 7'd10);
    assign hold_exit = (state == SAVED || state == FAILED) && tick && (hold <= HW'(1));
    assign save_done = (state == CONVERT) && (state_nx == SAVED);
`ifdef UI_MESSAGE_FRAME_SYNC_EN
    assign disp_load = tick;
`else
    assign disp_load = 1'b1;
`endif
    always_comb begin
        state_nx = state;
        if (export_fail)
            state_nx = FAILED;
        else if (export_done)
            state_nx = CONVERT;
        else if (export_start)
            state_nx = EXPORT;
        else if (state == IDLE && !camera_detected)
            state_nx = NODET;
        else if (state == NODET && camera_detected)
            state_nx = IDLE;
        else if (conv_done)
            state_nx = SAVED;
        else if (hold_exit)
            state_nx = camera_detected ? IDLE : NODET;
    end
    assign nx_idx = (state == EXPORT || state == CONVERT) ? 3'd1 :
                    (state == SAVED)  ? 3'd2 :
                    (state == FAILED) ? 3'd3 : 3'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            vsync_d        <= 1'b1;
            hold           <= '0;
            rem            <= '0;
            tens           <= '0;
            bcd            <= '0;
            busy           <= 1'b0;
            ui_enable      <= 1'b0;
            string_index   <= 3'd0;
            save_index_bcd <= 8'h00;
        end else begin
            vsync_d <= vsync;
            state   <= state_nx;
            busy    <= (state == CONVERT);
            // A fail in the same cycle as done wins, so the slot is not latched.
            if (export_done && !export_fail) begin
                rem  <= (32'(export_slot) > 32'd99) ? 7'd99 : 7'(export_slot);
                tens <= 4'd0;
            end else if (state == CONVERT && !conv_done) begin
                rem  <= rem - 7'd10;
                tens <= tens + 4'd1;
            end
            if (save_done)
                bcd <= {tens, rem[3:0]};
            if (export_fail || save_done)
                hold <= HW'(HOLD_EFF);
            else if (tick && hold != '0)
                hold <= hold - HW'(1);
            if (disp_load) begin
                ui_enable      <= (state != IDLE);
                string_index   <= nx_idx;
                save_index_bcd <= bcd;
            end
        end
    end
endmodule

// File: tb/tb_ui_message_ctrl.sv
// tb_ui_message_ctrl: table-driven check of ui_message_ctrl with HOLD_FRAMES=3.
module tb_ui_message_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       camera_detected = 1'b0;
    logic       export_start = 1'b0;
    logic       export_done = 1'b0;
    logic       export_fail = 1'b0;
    logic [6:0] export_slot = '0;
    logic       ui_enable;
    logic [2:0] string_index;
    logic [7:0] save_index_bcd;
    logic       busy;

    ui_message_ctrl #(.HOLD_FRAMES(3), .SLOT_WIDTH(7)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .camera_detected(camera_detected),
        .export_start(export_start), .export_done(export_done), .export_fail(export_fail),
        .export_slot(export_slot), .ui_enable(ui_enable), .string_index(string_index),
        .save_index_bcd(save_index_bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vs, cam, st, dn, fl;
        logic [6:0] slot;
        int         n;
        logic       en;
        logic [2:0] idx;
        logic [7:0] bcd;
        logic       bsy;
    } vec_t;
    typedef struct {
        logic       en;
        logic [2:0] idx;
        logic [7:0] bcd;
        logic       bsy;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];
    int   nvec = 0;
    int   nfail = 0;

    function automatic vec_t mk(logic vs, logic cam, logic st, logic dn, logic fl, logic [6:0] slot,
                                int n, logic en, logic [2:0] idx, logic [7:0] bcd, logic bsy);
        vec_t v;
        v.vs = vs; v.cam = cam; v.st = st; v.dn = dn; v.fl = fl; v.slot = slot;
        v.n = n; v.en = en; v.idx = idx; v.bcd = bcd; v.bsy = bsy;
        return v;
    endfunction

    task automatic check(input string name);
        exp_t e;
        nvec++;
        if (sb.size() == 0) begin
            nfail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if ({ui_enable, string_index, save_index_bcd, busy} !== {e.en, e.idx, e.bcd, e.bsy}) begin
                nfail++;
                $display("FAIL %s: got en=%b idx=%0d bcd=%h busy=%b, want en=%b idx=%0d bcd=%h busy=%b",
                         name, ui_enable, string_index, save_index_bcd, busy, e.en, e.idx, e.bcd, e.bsy);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        vsync = v.vs; camera_detected = v.cam; export_start = v.st;
        export_done = v.dn; export_fail = v.fl; export_slot = v.slot;
        e.en = v.en; e.idx = v.idx; e.bcd = v.bcd; e.bsy = v.bsy;
        sb.push_back(e);
        for (int i = 0; i < v.n; i++) begin
            @(posedge clk);
            #1;
            export_start = 1'b0; export_done = 1'b0; export_fail = 1'b0;
        end
        check(name);
    endtask

    task automatic do_reset(input logic cam, input string name);
        exp_t e;
        @(negedge clk);
        reset = 1'b1; vsync = 1'b0; camera_detected = cam;
        export_start = 1'b0; export_done = 1'b0; export_fail = 1'b0;
        e.en = 1'b0; e.idx = 3'd0; e.bcd = 8'h00; e.bsy = 1'b0;
        sb.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        check(name);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef UI_MESSAGE_FRAME_SYNC_EN
        tv.push_back(mk(0,1,0,0,0,0,2, 0,0,8'h00,0));
        tv.push_back(mk(0,1,1,0,0,0,3, 0,0,8'h00,0));
        tv.push_back(mk(1,1,0,0,0,0,1, 1,1,8'h00,0));
        tv.push_back(mk(1,1,0,0,1,0,3, 1,1,8'h00,0));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,1,8'h00,0));
        tv.push_back(mk(1,1,0,0,0,0,1, 1,3,8'h00,0));
        do_reset(1'b1, "reset");
`else
        // camera presence
        tv.push_back(mk(0,0,0,0,0,0,2, 1,0,8'h00,0));
        tv.push_back(mk(0,1,0,0,0,0,2, 0,0,8'h00,0));
        // start then done with slot 47: busy for 5 cycles
        tv.push_back(mk(0,1,1,0,0,0,2, 1,1,8'h00,0));
        tv.push_back(mk(0,1,0,1,0,47,1, 1,1,8'h00,0));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,1,8'h00,1));
        tv.push_back(mk(0,1,0,0,0,0,4, 1,1,8'h00,1));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,2,8'h47,0));
        // three ticks end the saved message
        tv.push_back(mk(1,1,0,0,0,0,1, 1,2,8'h47,0));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,2,8'h47,0));
        tv.push_back(mk(1,1,0,0,0,0,1, 1,2,8'h47,0));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,2,8'h47,0));
        tv.push_back(mk(1,1,0,0,0,0,1, 1,2,8'h47,0));
        tv.push_back(mk(0,1,0,0,0,0,1, 0,0,8'h47,0));
        // slot 120 clamps to 99 with the 10-cycle worst case
        tv.push_back(mk(0,1,0,1,0,120,1, 0,0,8'h47,0));
        tv.push_back(mk(0,1,0,0,0,0,10, 1,1,8'h47,1));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,2,8'h99,0));
        // slot 0 converts in one cycle
        tv.push_back(mk(0,1,0,1,0,0,1, 1,2,8'h99,0));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,1,8'h99,1));
        tv.push_back(mk(0,1,0,0,0,0,1, 1,2,8'h00,0));
        // done and fail together
        tv.push_back(mk(0,1,0,1,1,5,2, 1,3,8'h00,0));
        // fail aborts conversion, start abandons hold
        tv.push_back(mk(0,1,0,1,0,93,3, 1,1,8'h00,1));
        tv.push_back(mk(0,1,0,0,1,0,2, 1,3,8'h00,0));
        tv.push_back(mk(0,1,1,0,0,0,2, 1,1,8'h00,0));
        for (int i = 0; i < 6; i++) tv.push_back(mk(logic'(i % 2 == 0),1,0,0,0,0,1, 1,1,8'h00,0));
        tv.push_back(mk(0,0,0,0,0,0,2, 1,1,8'h00,0));
        // fail with camera lost exits to not-detected
        tv.push_back(mk(0,0,0,0,1,0,2, 1,3,8'h00,0));
        for (int i = 0; i < 4; i++) tv.push_back(mk(logic'(i % 2 == 0),0,0,0,0,0,1, 1,3,8'h00,0));
        tv.push_back(mk(1,0,0,0,0,0,2, 1,0,8'h00,0));
        // re-entry reloads the hold counter
        tv.push_back(mk(0,1,0,0,1,0,2, 1,3,8'h00,0));
        for (int i = 0; i < 4; i++) tv.push_back(mk(logic'(i % 2 == 0),1,0,0,0,0,1, 1,3,8'h00,0));
        tv.push_back(mk(0,1,0,0,1,0,1, 1,3,8'h00,0));
        for (int i = 0; i < 4; i++) tv.push_back(mk(logic'(i % 2 == 0),1,0,0,0,0,1, 1,3,8'h00,0));
        tv.push_back(mk(1,1,0,0,0,0,2, 0,0,8'h00,0));
        do_reset(1'b0, "reset");
`endif
        for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("vec%0d", i));
`ifndef UI_MESSAGE_FRAME_SYNC_EN
        // reset mid-conversion forgets everything
        apply(mk(0,1,0,1,0,60,2, 1,1,8'h00,1), "pre_reset_convert");
        do_reset(1'b1, "mid_reset");
        apply(mk(0,1,0,0,0,0,12, 0,0,8'h00,0), "post_reset_idle");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/ui_message_ctrl.md
Name: ui_message_ctrl

Overview:
- Sequencer directly upstream of the on-screen text overlay.
- Turns camera-presence status and SRAM-export events into the overlay's controls: `ui_enable`, a 3-bit `string_index` and a 2-digit BCD save-slot number.
- Holds result messages for a fixed number of video frames.
- Converts the binary export slot to BCD with a multi-cycle serial converter.

Parameters:
- HOLD_FRAMES, 120, number of `vsync` rising edges a "Saved"/"Fail" message stays displayed (0 is treated as 1).
- SLOT_WIDTH, 7, width of the binary `export_slot` input.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- vsync  input  1  video vertical sync, clk domain; rising edge marks a frame boundary.
- camera_detected  input  1  level; 1 when the camera responds.
- export_start  input  1  one-cycle pulse; SRAM export began.
- export_done  input  1  one-cycle pulse; export succeeded, slot valid on `export_slot` in the same cycle.
- export_fail  input  1  one-cycle pulse; export failed (no free slots).
- export_slot  input  SLOT_WIDTH  binary slot number, sampled only with `export_done`.
- ui_enable  output  1  overlay visible.
- string_index  output  3  0 = not detected, 1 = SRAM exporting, 2 = saved, 3 = fail.
- save_index_bcd  output  8  [7:4] tens digit, [3:0] units digit.
- busy  output  1  1 while the BCD conversion is running.

Behaviour:
- Reset values: `ui_enable`=0, `string_index`=0, `save_index_bcd`=8'h00, `busy`=0, state=IDLE, hold counter=0.
- `vsync_d` resets to 1, so a high `vsync` at reset release is not a rising edge.
- Frame tick: `tick` = `vsync` & ~`vsync_d`.
- States and their displayed values:
  - IDLE: enable 0.
  - NODET: enable 1, index 0.
  - EXPORT: enable 1, index 1.
  - CONVERT: enable 1, index 1.
  - SAVED: enable 1, index 2.
  - FAILED: enable 1, index 3.
- Event priority, evaluated in every state in this order:
  1. `export_fail` → FAILED.
  2. `export_done` → CONVERT (slot latched).
  3. `export_start` → EXPORT.
  4. State-local rules below.
- Simultaneous `export_done` and `export_fail`: fail wins; the slot is not latched.
- `export_done` or `export_fail` without a preceding start is accepted.
- State-local rules:
  - IDLE: if `camera_detected`=0 → NODET.
  - NODET: if `camera_detected`=1 → IDLE.
  - EXPORT: stays until an event arrives; camera loss does not interrupt it.
  - CONVERT: on conversion done → SAVED.
  - SAVED/FAILED: leave on the HOLD_FRAMES-th tick after entry. Exit to NODET if `camera_detected`=0, else IDLE.
  - SAVED/FAILED re-entry (a new fail, or done then conversion) reloads the hold counter.
- BCD conversion:
  - Latch slot into a 7-bit remainder; slot > 99 is clamped to 99.
  - Tens register cleared on start.
  - Each cycle: if remainder ≥ 10, subtract 10 and increment tens; else done.
  - Latency from the `export_done` cycle to SAVED is (tens+1) cycles, at most 10.
  - `busy`=1 in CONVERT.
  - `save_index_bcd` updates on the done cycle only; it otherwise holds its last value, including through FAILED.
  - A new `export_done` during CONVERT restarts conversion with the new slot.
  - `export_fail` during CONVERT aborts it; `save_index_bcd` is unchanged.
- Hold counter width is $clog2(HOLD_FRAMES+1) bits and decrements only on tick.
- Outputs are registered: they reflect the state one cycle after the transition, subject to the optional feature below.
- Reset asserted mid-conversion or mid-hold returns everything to reset values on the next edge. No event is remembered.

Optional Feature:
- Macro: UI_MESSAGE_FRAME_SYNC_EN.
- Defined:
  - `ui_enable`, `string_index` and `save_index_bcd` load from the internal next-display values only on tick cycles.
  - The overlay then never changes mid-frame; display lags state by up to one frame.
  - Hold counting is unchanged.
- Undefined: outputs follow state one cycle after each transition, as in Behaviour.

Test Plan:
- Reset with `camera_detected`=0, then release → after 2 cycles `ui_enable`=1, `string_index`=0. Raise `camera_detected` → `ui_enable`=0 two cycles later.
- `export_start`, then `export_done` with slot=47 → `busy` high for 5 cycles, `string_index`=2, `save_index_bcd`=8'h47. With HOLD_FRAMES=3, `ui_enable` drops after the 3rd tick.
- `export_done` with slot=120 → `save_index_bcd`=8'h99. Slot=0 → 8'h00 with 1-cycle conversion.
- `export_done` (slot=5) and `export_fail` in the same cycle → `string_index`=3, `save_index_bcd` keeps its prior value, `busy` stays 0.
- `export_done` slot=93, then `export_fail` 3 cycles later → FAILED, `save_index_bcd` unchanged. Then `export_start` during FAILED → `string_index`=1 with the hold timer abandoned.
- With UI_MESSAGE_FRAME_SYNC_EN defined, `export_start` mid-frame → `string_index` stays at its old value until the next `vsync` rise, then becomes 1 on the following cycle.
